// File: rtl/cwm_c2d_pkg.sv
// Shared sizing and FSM types for the CWM chip-to-DRAM mover.
// Word geometry follows from M; N_BEATS is the number of stream beats per CWM word.
package cwm_c2d_pkg;

  localparam int M                   = 32;
  localparam int CWM_DEPTH           = 1024;
  localparam int DDR_AXI_ADDR_WIDTH  = 32;
  localparam int DDR_LEN_WIDTH       = 20;
  localparam int DDR_AXIS_DATA_WIDTH = 512;

  localparam int WORD_W     = M * 4 * 8;
  localparam int WORD_BYTES = M * 4;
  localparam int N_BEATS    = WORD_W / DDR_AXIS_DATA_WIDTH;
  localparam int CA_W       = $clog2(CWM_DEPTH);
  localparam int BEAT_W     = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  function automatic logic [31:0] word_count(input logic [31:0] nbytes);
    return nbytes / 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/cwm_c2d_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module cwm_c2d_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push && (count_r != CNT_W'(DEPTH));
  assign pop_ok_s  = pop && (count_r != CNT_W'(0));
  assign rdata     = mem_r[rptr_r];
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_ok_s) begin
        wptr_r <= wptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cwm_c2d.sv
// CWM-to-DRAM mover: reads a CWM word range and streams it as AXIS beats to the DMA writer.
// Optional macro CWM_C2D_PIPE_EN adds a register stage on the read request and on dout capture.
module cwm_c2d
  import cwm_c2d_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_pulse,
  input  logic [31:0]                    c_addr,
  input  logic [31:0]                    d_addr,
  input  logic [31:0]                    n_bytes,
  output logic                           busy,
  output logic                           done_pulse,
  output logic [DDR_AXI_ADDR_WIDTH-1:0]  dma_wr_desc_addr,
  output logic [DDR_LEN_WIDTH-1:0]       dma_wr_desc_len,
  output logic                           dma_wr_desc_valid,
  input  logic                           dma_wr_desc_ready,
  input  logic                           dma_wr_desc_status_valid,
  output logic [DDR_AXIS_DATA_WIDTH-1:0] dma_wr_write_data_tdata,
  output logic                           dma_wr_write_data_tvalid,
  input  logic                           dma_wr_write_data_tready,
  output logic                           dma_wr_write_data_tlast,
  output logic                           rd_en,
  output logic [CA_W-1:0]                rd_addr,
  input  logic [WORD_W-1:0]              dout
);

`ifdef CWM_C2D_PIPE_EN
  localparam int LAT_EFF = RD_LAT + 2;
`else
  localparam int LAT_EFF = RD_LAT;
`endif
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CRD_W = $clog2(FIFO_DEPTH + LAT_EFF + 2) + 1;

  state_e                          state_r;
  state_e                          state_nxt_s;
  logic [31:0]                     w_in_s;
  logic                            start_ok_s;
  logic                            start_nz_s;
  logic                            start_zero_s;
  logic [31:0]                     words_total_r;
  logic [31:0]                     words_issued_r;
  logic [31:0]                     words_sent_r;
  logic [BEAT_W-1:0]               beat_idx_r;
  logic                            rd_en_r;
  logic [CA_W-1:0]                 rd_addr_r;
  logic [LAT_EFF-1:0]              vld_sr_r;
  logic                            busy_r;
  logic                            done_r;
  logic                            desc_valid_r;
  logic [DDR_AXI_ADDR_WIDTH-1:0]   desc_addr_r;
  logic [DDR_LEN_WIDTH-1:0]        desc_len_r;
  logic [CRD_W-1:0]                occ_s;
  logic                            issue_s;
  logic                            fifo_push_s;
  logic [WORD_W-1:0]               fifo_wdata_s;
  logic [WORD_W-1:0]               fifo_rdata_s;
  logic                            fifo_empty_s;
  logic [CNT_W-1:0]                fifo_count_s;
  logic [N_BEATS-1:0][DDR_AXIS_DATA_WIDTH-1:0] beats_s;
  logic                            tvalid_s;
  logic                            hs_s;
  logic                            last_beat_s;
  logic                            last_word_s;
  logic                            pop_s;
  logic                            unused_s;

  assign unused_s     = ^c_addr[31:CA_W];
  assign w_in_s       = word_count(n_bytes);
  assign start_ok_s   = (state_r == ST_IDLE) && start_pulse;
  assign start_nz_s   = start_ok_s && (w_in_s != 32'd0);
  assign start_zero_s = start_ok_s && (w_in_s == 32'd0);

  assign tvalid_s    = (state_r == ST_RUN) && !fifo_empty_s;
  assign hs_s        = tvalid_s && dma_wr_write_data_tready;
  assign last_beat_s = (beat_idx_r == BEAT_W'(N_BEATS - 1));
  assign last_word_s = (words_sent_r == (words_total_r - 32'd1));
  assign pop_s       = hs_s && last_beat_s;
  assign beats_s     = fifo_rdata_s;

  // credit = FIFO occupancy plus every read still travelling through the latency pipe
  always_comb begin
    occ_s = CRD_W'(fifo_count_s) + CRD_W'(rd_en_r);
    for (int i = 0; i < LAT_EFF; i++) begin
      occ_s = occ_s + CRD_W'(vld_sr_r[i]);
    end
    if (start_nz_s) begin
      issue_s = 1'b1;
    end else begin
      issue_s = (state_r == ST_RUN) && (words_issued_r < words_total_r) &&
                (occ_s < CRD_W'(FIFO_DEPTH));
    end
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_nz_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hs_s && last_beat_s && last_word_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (dma_wr_desc_status_valid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // read-valid delay line; a set tap at the end means dout (or its capture) holds a requested word
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_r <= '0;
    end else begin
      vld_sr_r[0] <= rd_en_r;
      for (int i = 1; i < LAT_EFF; i++) begin
        vld_sr_r[i] <= vld_sr_r[i-1];
      end
    end
  end

  // control, descriptor, read issue and serialiser counters
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      desc_valid_r   <= 1'b0;
      desc_addr_r    <= '0;
      desc_len_r     <= '0;
      rd_en_r        <= 1'b0;
      rd_addr_r      <= '0;
      words_total_r  <= 32'd0;
      words_issued_r <= 32'd0;
      words_sent_r   <= 32'd0;
      beat_idx_r     <= '0;
    end else begin
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= start_zero_s || ((state_r == ST_WAIT) && dma_wr_desc_status_valid);
      rd_en_r <= issue_s;
      if (start_nz_s) begin
        desc_valid_r   <= 1'b1;
        desc_addr_r    <= d_addr[DDR_AXI_ADDR_WIDTH-1:0];
        desc_len_r     <= n_bytes[DDR_LEN_WIDTH-1:0];
        rd_addr_r      <= c_addr[CA_W-1:0];
        words_total_r  <= w_in_s;
        words_issued_r <= 32'd1;
        words_sent_r   <= 32'd0;
        beat_idx_r     <= '0;
      end else begin
        if (dma_wr_desc_ready) begin
          desc_valid_r <= 1'b0;
        end
        if (issue_s) begin
          rd_addr_r      <= rd_addr_r + CA_W'(1);
          words_issued_r <= words_issued_r + 32'd1;
        end
        if (hs_s) begin
          beat_idx_r <= last_beat_s ? BEAT_W'(0) : beat_idx_r + BEAT_W'(1);
        end
        if (pop_s) begin
          words_sent_r <= words_sent_r + 32'd1;
        end
      end
    end
  end

`ifdef CWM_C2D_PIPE_EN
  logic              rd_en_q_r;
  logic [CA_W-1:0]   rd_addr_q_r;
  logic [WORD_W-1:0] dout_q_r;

  // timing-closure stages on the read request and the returned word
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q_r   <= 1'b0;
      rd_addr_q_r <= '0;
      dout_q_r    <= '0;
    end else begin
      rd_en_q_r   <= rd_en_r;
      rd_addr_q_r <= rd_addr_r;
      dout_q_r    <= dout;
    end
  end

  assign rd_en        = rd_en_q_r;
  assign rd_addr      = rd_addr_q_r;
  assign fifo_wdata_s = dout_q_r;
`else
  assign rd_en        = rd_en_r;
  assign rd_addr      = rd_addr_r;
  assign fifo_wdata_s = dout;
`endif

  assign fifo_push_s = vld_sr_r[LAT_EFF-1];

  cwm_c2d_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .wdata (fifo_wdata_s),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign busy                     = busy_r;
  assign done_pulse               = done_r;
  assign dma_wr_desc_valid        = desc_valid_r;
  assign dma_wr_desc_addr         = desc_addr_r;
  assign dma_wr_desc_len          = desc_len_r;
  assign dma_wr_write_data_tvalid = tvalid_s;
  assign dma_wr_write_data_tlast  = tvalid_s && last_beat_s && last_word_s;
  // gate the head word so stale FIFO contents never reach the bus
  assign dma_wr_write_data_tdata  = tvalid_s ? beats_s[beat_idx_r] : '0;

endmodule

// File: doc/cwm_c2d.md
# cwm_c2d

Chip-to-DRAM mover for the convolution weight memory (CWM): the write-back counterpart of the CWM load path. On a start pulse it reads a contiguous range of CWM words through the CWM read port and serialises each word into `DDR_AXIS_DATA_WIDTH`-bit AXI-Stream beats. It feeds the DMA write controller, which stores them at a DRAM byte address; the block handles controller backpressure and reports completion. It sits beside the CWM load path under the memory-subsystem controller and is used for weight readback and debug dumps.

## Interface
- `RD_LAT`, 2: CWM read latency in cycles, from `rd_en` to `dout` valid.
- `FIFO_DEPTH`, 4: word-buffer depth in CWM words; power of two, at least `RD_LAT`+2.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous reset, active-high.
- `start_pulse` in 1: one-cycle transfer request; ignored while `busy`.
- `c_addr` in 32: first CWM word address; low `$clog2(CWM_DEPTH)` bits used.
- `d_addr` in 32: DRAM byte address.
- `n_bytes` in 32: transfer length; multiple of `M`*4.
- `busy` out 1: transfer in progress.
- `done_pulse` out 1: one-cycle completion strobe.
- `dma_wr_desc_addr` out `DDR_AXI_ADDR_WIDTH`, `dma_wr_desc_len` out `DDR_LEN_WIDTH`, `dma_wr_desc_valid` out 1, `dma_wr_desc_ready` in 1: write descriptor.
- `dma_wr_desc_status_valid` in 1: DMA write finished.
- `dma_wr_write_data_tdata` out `DDR_AXIS_DATA_WIDTH`, `dma_wr_write_data_tvalid` out 1, `dma_wr_write_data_tready` in 1, `dma_wr_write_data_tlast` out 1: write data stream.
- `rd_en` out 1, `rd_addr` out `$clog2(CWM_DEPTH)`, `dout` in `M*4*8`: CWM read port.

## Operation
- N = `M`*4*8/`DDR_AXIS_DATA_WIDTH` beats per word. W = `n_bytes`/(`M`*4) words.
- States and transitions:
  - IDLE to RUN on `start_pulse`, which latches the addresses and W.
  - RUN to WAIT when the last beat handshakes.
  - WAIT to IDLE on `dma_wr_desc_status_valid`; `done_pulse` is raised in that transition.
- `n_bytes`=0: no descriptor and no reads; `done_pulse` fires 1 cycle after `start_pulse` and the block stays IDLE.
- Descriptor: `dma_wr_desc_valid` asserts 1 cycle after start and holds until `dma_wr_desc_ready`; addr = `d_addr`, len = `n_bytes` (truncated to width).
- Read issue uses credit control. Issue `rd_en` only while (FIFO occupancy + reads in flight) < `FIFO_DEPTH` and words issued < W. `rd_addr` increments per issue and wraps modulo `CWM_DEPTH`.
- Read data enters the word FIFO exactly `RD_LAT` cycles after `rd_en`. The FIFO never overflows by construction; overflow is an assertion failure.
- Serialiser: beat k of a word = `dout[k*DDR_AXIS_DATA_WIDTH +: DDR_AXIS_DATA_WIDTH]`, k = 0..N-1, LSB first.
  - Beat index advances only on tvalid&tready.
  - The FIFO pops on the handshake of beat N-1.
  - `tlast` is 1 only on beat N-1 of word W-1.
- `tdata` and `tlast` stay stable while tvalid=1 and tready=0.
- `start_pulse` in RUN or WAIT is ignored, with no state change.
- `rst` mid-transfer: back to IDLE, FIFO and counters cleared, in-flight read data discarded. The DMA engine is not aborted; the controller is responsible for that.

## Timing
- Reset value of every output: 0, including `busy`, `done_pulse`, all `dma_wr_*` outputs, `rd_en` and `rd_addr`.
- Start accepted at cycle T:
  - T+1: `busy`=1, desc_valid=1, first `rd_en`.
  - T+1+`RD_LAT`: first word written into the FIFO.
  - T+2+`RD_LAT`: first `tvalid`.
- Throughput with tready held at 1: one beat per cycle, with no bubbles across word boundaries.
- `done_pulse` is asserted the cycle after `status_valid` is sampled in WAIT. `busy` falls in the same cycle.

## Configuration
- `CWM_C2D_PIPE_EN` defined: one extra register stage on `rd_en`/`rd_addr` and one on `dout` capture. Effective latency becomes `RD_LAT`+2; the credit logic counts those stages as in-flight. Used for timing closure on large-M builds.
- `CWM_C2D_PIPE_EN` undefined: direct connection with effective latency `RD_LAT`.

## Structure
- `incl.vh` provides `M`, `CWM_DEPTH`, `DDR_AXI_ADDR_WIDTH`, `DDR_LEN_WIDTH` and `DDR_AXIS_DATA_WIDTH`, and gets a new localparam-style macro for N.
- State encodings are localparams in the module.
- One sub-module, `cwm_c2d_fifo`: a synchronous FWFT word FIFO parameterised by width and depth, with count output. Reuse `shift_reg` for the read-valid delay line.

## Test plan
All scenarios use M=32, DDR width 512, so N=2 and a word is 128 B.
- Start with `c_addr`=5, `d_addr`=0x1000, `n_bytes`=512, tready held at 1 -> descriptor (0x1000, 512), `rd_addr` 5..8, 8 beats in low/high-half order, `tlast` on beat 8, `done_pulse` 1 cycle after status.
- Same transfer with tready toggled by a random pattern (50%) -> identical beat sequence, data stable while stalled, FIFO count never above 4.
- `c_addr`=`CWM_DEPTH`-2, 4 words -> `rd_addr` sequence `CWM_DEPTH`-2, `CWM_DEPTH`-1, 0, 1.
- `n_bytes`=0 -> no desc_valid, no `rd_en`, `done_pulse` at T+1.
- Second `start_pulse` mid-RUN, and `rst` mid-RUN -> the second start is ignored; after reset every output is 0, and a fresh 256 B transfer completes correctly.
- Build with `CWM_C2D_PIPE_EN` defined -> first `tvalid` at T+4+`RD_LAT`, data identical to the unpipelined build.
